uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  Parametrised UART receive engine; next generation of the single-tick receiver FSM.
//  Samples the serial line on an oversampled tick with a mid-bit vote, and frames
//  DATA_BITS of data with optional parity and 1/2 stop bits.
//  Delivers each byte plus error flags through a one-entry valid/ready holding register.
//  Sits between the baud generator (os_tick source) and the RX FIFO / register block.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9, sent LSB first
//  OVERSAMPLE  16  os_tick pulses per bit, even, legal 8..16
//  PARITY_EN   1   1 = parity bit present after data, 0 = no parity bit
//  PARITY_ODD  0   1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
//  STOP_BITS   1   number of stop bits, legal 1 or 2
// PORTS
//  clk            in   1          system clock
//  nrst           in   1          asynchronous active-low reset
//  os_tick        in   1          oversample strobe, one clk wide, OVERSAMPLE per bit
//  rx_i           in   1          asynchronous serial line, idle high
//  rx_data_o      out  DATA_BITS  received data (holding register)
//  rx_valid_o     out  1          holding register full
//  rx_ready_i     in   1          consumer accepts; transfer when valid & ready
//  parity_err_o   out  1          parity mismatch on held frame
//  frame_err_o    out  1          a stop bit sampled 0 on held frame
//  break_o        out  1          held frame is a break: all bits incl. stop = 0
//  overrun_err_o  out  1          sticky; a frame completed while rx_valid_o=1
//  busy_o         out  1          FSM not in IDLE
// BEHAVIOUR
//  - Reset (async, nrst=0):
//      - all outputs 0, FSM=IDLE, counters 0.
//      - 2-flop rx synchroniser resets to 1. rx_s = synchronised line, 2 clk latency.
//  - Counters:
//      - tick_cnt counts os_tick modulo OVERSAMPLE.
//      - bit_cnt counts 0..DATA_BITS-1, width $clog2(DATA_BITS+1).
//  - FSM states and transitions:
//      - IDLE: rx_s=0 -> START, tick_cnt=0.
//      - START: at tick_cnt=OVERSAMPLE/2-1, sample rx_s.
//          - 1 -> IDLE (glitch rejected, nothing reported).
//          - 0 -> DATA, tick_cnt=0, bit_cnt=0.
//      - DATA: sample every OVERSAMPLE ticks (bit centre) and shift into shreg[bit_cnt].
//          - After bit DATA_BITS-1: go to PARITY if PARITY_EN, else STOP.
//      - PARITY: one centre sample.
//          - perr = ^data ^ pbit ^ PARITY_ODD (nonzero = error).
//      - STOP: STOP_BITS centre samples.
//          - ferr = any stop sample 0.
//          - Frame completes on the last stop sample; see frame completion below.
//          - Then go to IDLE if the last stop sample = 1, else to WAIT_HIGH.
//      - WAIT_HIGH: stay until rx_s=1, then IDLE. A held-low line never re-triggers.
//  - Frame completion (the clk after the final os_tick):
//      - If rx_valid_o=0, or rx_valid_o=1 & rx_ready_i=1 the same cycle:
//          - load rx_data_o, parity_err_o, frame_err_o, break_o.
//          - set rx_valid_o=1.
//      - Else: frame dropped, old data and flags kept, overrun_err_o<=1.
//  - break = data==0 & (no parity or pbit==0) & ferr. break implies frame_err_o=1.
//  - Handshake:
//      - rx_valid_o & rx_ready_i clears rx_valid_o and the per-frame flags next clk,
//        unless a new frame loads in that same clk.
//      - overrun_err_o clears only on a handshake.
//  - os_tick ignored in IDLE and WAIT_HIGH.
//  - rx_ready_i while rx_valid_o=0 has no effect.
//  - busy_o=0 only in IDLE.
// TESTING
//  1. 8E1, send 0x55 with parity 0 at OVERSAMPLE=16 -> rx_valid_o=1, rx_data_o=0x55,
//     all errors 0.
//  2. rx_i low for 4 os_ticks then high -> back to IDLE, rx_valid_o stays 0, busy_o pulses.
//  3. 8O2, send 0xA5 with wrong parity bit and 2nd stop=0 -> data 0xA5, parity_err_o=1,
//     frame_err_o=1.
//  4. Send 0x12 then 0x34, rx_ready_i=0 throughout -> rx_data_o=0x12, overrun_err_o=1;
//     ready=1 -> all clear next clk.
//  5. Hold rx_i low for 3 frame times -> one frame with break_o=1 and frame_err_o=1;
//     no second frame until rx_i returns high.
//  6. nrst pulse mid-DATA -> all outputs 0 immediately; next 0x3C frame received
//     cleanly (DATA_BITS=5,7,9 regressions too).

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// UART receiver: oversampled line, 3-sample majority vote at bit centre, optional parity,
// 1/2 stop bits, and a one-entry valid/ready holding register with error flags.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 os_tick,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 overrun_err_o,
  output logic                 busy_o
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_EN    = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [1:0]           hist_q;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pbit_q, pbit_d;
  logic                 ferr_q, ferr_d;
  logic                 frame_done;
  logic                 vote;
  logic                 at_half, at_full;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 fflag_q, fflag_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;
  logic                 new_perr, new_brk;
  logic                 handshake, load;

  // Line synchroniser plus the two previous tick samples for the majority vote.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      hist_q    <= 2'b11;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      if (os_tick) hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign vote    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
  assign at_half = os_tick && (tick_q == HALF_LAST);
  assign at_full = os_tick && (tick_q == FULL_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      pbit_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      pbit_q  <= pbit_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    pbit_d     = pbit_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        ferr_d = 1'b0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (at_half) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = vote ? S_IDLE : S_DATA;
        end else if (os_tick) begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_DATA: begin
        if (at_full) begin
          tick_d  = '0;
          // LSB arrives first, so after DATA_BITS shifts it sits in bit 0.
          shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else if (os_tick) begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_PARITY: begin
        if (at_full) begin
          tick_d  = '0;
          pbit_d  = vote;
          state_d = S_STOP;
        end else if (os_tick) begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_STOP: begin
        if (at_full) begin
          tick_d = '0;
          if (!vote) ferr_d = 1'b1;
          if (bit_q == STOP_LAST) begin
            bit_d      = '0;
            frame_done = 1'b1;
            state_d    = vote ? S_IDLE : S_WAIT_HIGH;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else if (os_tick) begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ferr_d already folds in the final stop sample taken this cycle.
  assign new_perr  = PAR_EN & ((^shreg_q) ^ pbit_q ^ PAR_ODD);
  assign new_brk   = (shreg_q == '0) & (~PAR_EN | ~pbit_q) & ferr_d;
  assign handshake = valid_q & rx_ready_i;
  assign load      = frame_done & (~valid_q | rx_ready_i);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    fflag_d = fflag_q;
    brk_d   = brk_q;
    ovr_d   = ovr_q;
    if (handshake) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      fflag_d = 1'b0;
      brk_d   = 1'b0;
      ovr_d   = 1'b0;
    end
    if (load) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      perr_d  = new_perr;
      fflag_d = ferr_d;
      brk_d   = new_brk;
    end else if (frame_done) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      fflag_q <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      fflag_q <= fflag_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign parity_err_o  = perr_q;
  assign frame_err_o   = fflag_q;
  assign break_o       = brk_q;
  assign overrun_err_o = ovr_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: five frame formats share clk, os_tick,
// reset and ready; only the selected instance sees serial traffic.
module tb_uart_rx_oversampled;

  logic       clk;
  logic       nrst;
  logic       os_tick;
  logic       line;
  logic [2:0] sel;
  logic       ready;
  wire  [4:0] rx_l;

  wire  [7:0] data_a, data_b;
  wire  [4:0] data_c;
  wire  [6:0] data_d;
  wire  [8:0] data_e;
  wire  [4:0] valid, perr, ferr, brk, ovr, busy;

  int n_checks = 0;
  int n_errors = 0;

  assign rx_l = {5{line}} | ~(5'b00001 << sel);

  // a: 8E1  b: 8O2  c: 5N1 at 8x  d: 7E1  e: 9O2
  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .nrst(nrst), .os_tick(os_tick), .rx_i(rx_l[0]), .rx_data_o(data_a),
    .rx_valid_o(valid[0]), .rx_ready_i(ready), .parity_err_o(perr[0]), .frame_err_o(ferr[0]),
    .break_o(brk[0]), .overrun_err_o(ovr[0]), .busy_o(busy[0]));
  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_b (
    .clk(clk), .nrst(nrst), .os_tick(os_tick), .rx_i(rx_l[1]), .rx_data_o(data_b),
    .rx_valid_o(valid[1]), .rx_ready_i(ready), .parity_err_o(perr[1]), .frame_err_o(ferr[1]),
    .break_o(brk[1]), .overrun_err_o(ovr[1]), .busy_o(busy[1]));
  uart_rx_oversampled #(.DATA_BITS(5), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_c (
    .clk(clk), .nrst(nrst), .os_tick(os_tick), .rx_i(rx_l[2]), .rx_data_o(data_c),
    .rx_valid_o(valid[2]), .rx_ready_i(ready), .parity_err_o(perr[2]), .frame_err_o(ferr[2]),
    .break_o(brk[2]), .overrun_err_o(ovr[2]), .busy_o(busy[2]));
  uart_rx_oversampled #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d (
    .clk(clk), .nrst(nrst), .os_tick(os_tick), .rx_i(rx_l[3]), .rx_data_o(data_d),
    .rx_valid_o(valid[3]), .rx_ready_i(ready), .parity_err_o(perr[3]), .frame_err_o(ferr[3]),
    .break_o(brk[3]), .overrun_err_o(ovr[3]), .busy_o(busy[3]));
  uart_rx_oversampled #(.DATA_BITS(9), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_e (
    .clk(clk), .nrst(nrst), .os_tick(os_tick), .rx_i(rx_l[4]), .rx_data_o(data_e),
    .rx_valid_o(valid[4]), .rx_ready_i(ready), .parity_err_o(perr[4]), .frame_err_o(ferr[4]),
    .break_o(brk[4]), .overrun_err_o(ovr[4]), .busy_o(busy[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // os_tick every 4 clk, so one bit lasts OVERSAMPLE*4 clk.
  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 os_tick = 1'b1;
      @(posedge clk);
      #1 os_tick = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v, input int cpb);
    line = v;
    repeat (cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input bit par_en,
                            input logic pbit, input int nstop, input logic stop2, input int cpb);
    send_bit(1'b0, cpb);
    for (int i = 0; i < nbits; i++) send_bit(d[i], cpb);
    if (par_en) send_bit(pbit, cpb);
    send_bit(1'b1, cpb);
    if (nstop == 2) send_bit(stop2, cpb);
    send_bit(1'b1, cpb);
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  initial begin
    nrst  = 1'b0;
    line  = 1'b1;
    sel   = 3'd0;
    ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", valid, 5'h00);
    check_eq("rst_flags", {perr, ferr, brk, ovr}, 20'h0);
    check_eq("rst_busy", busy, 5'h00);
    check_eq("rst_data_a", data_a, 8'h00);
    #1 nrst = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // 8E1 0x55, even parity bit 0
    send_frame(9'h055, 8, 1, 1'b0, 1, 1'b1, 64);
    @(negedge clk);
    check_eq("t1_valid", valid[0], 1'b1);
    check_eq("t1_data", data_a, 8'h55);
    check_eq("t1_errs", {perr[0], ferr[0], brk[0], ovr[0]}, 4'h0);
    check_eq("t1_busy", busy[0], 1'b0);
    pulse_ready();
    @(negedge clk);
    check_eq("t1_cleared", valid[0], 1'b0);

    // short low glitch is rejected at start centre
    #1 line = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_eq("t2_busy_hi", busy[0], 1'b1);
    repeat (4) @(posedge clk);
    #1 line = 1'b1;
    repeat (128) @(posedge clk);
    @(negedge clk);
    check_eq("t2_busy_lo", busy[0], 1'b0);
    check_eq("t2_valid", valid[0], 1'b0);

    // 8O2 0xA5: correct odd parity would be 1, send 0; second stop 0
    #1 sel = 3'd1;
    send_frame(9'h0A5, 8, 1, 1'b0, 2, 1'b0, 64);
    @(negedge clk);
    check_eq("t3_valid", valid[1], 1'b1);
    check_eq("t3_data", data_b, 8'hA5);
    check_eq("t3_perr", perr[1], 1'b1);
    check_eq("t3_ferr", ferr[1], 1'b1);
    check_eq("t3_brk", brk[1], 1'b0);
    pulse_ready();
    @(negedge clk);
    check_eq("t3_cleared", {valid[1], perr[1], ferr[1]}, 3'b000);

    // overrun: 0x12 (pbit 0) then 0x34 (pbit 1) with ready low
    #1 sel = 3'd0;
    send_frame(9'h012, 8, 1, 1'b0, 1, 1'b1, 64);
    send_frame(9'h034, 8, 1, 1'b1, 1, 1'b1, 64);
    @(negedge clk);
    check_eq("t4_valid", valid[0], 1'b1);
    check_eq("t4_data", data_a, 8'h12);
    check_eq("t4_ovr", ovr[0], 1'b1);
    check_eq("t4_perr", perr[0], 1'b0);
    pulse_ready();
    @(negedge clk);
    check_eq("t4_clr", {valid[0], ovr[0], perr[0], ferr[0], brk[0]}, 5'h00);

    // break: line held low for three 11-bit frame times
    #1 line = 1'b0;
    repeat (3 * 11 * 64) @(posedge clk);
    @(negedge clk);
    check_eq("t5_valid", valid[0], 1'b1);
    check_eq("t5_data", data_a, 8'h00);
    check_eq("t5_brk", brk[0], 1'b1);
    check_eq("t5_ferr", ferr[0], 1'b1);
    check_eq("t5_perr", perr[0], 1'b0);
    check_eq("t5_ovr", ovr[0], 1'b0);
    check_eq("t5_wait_busy", busy[0], 1'b1);
    #1 line = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    check_eq("t5_idle", busy[0], 1'b0);
    check_eq("t5_no_second", ovr[0], 1'b0);

    // async reset mid-DATA while a break frame is still held
    #1 line = 1'b0;
    repeat (64) @(posedge clk);
    #1 line = 1'b0;
    repeat (128) @(posedge clk);
    #1 line = 1'b1;
    repeat (32) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    check_eq("t6_rst_busy", busy[0], 1'b0);
    check_eq("t6_rst_valid", valid[0], 1'b0);
    check_eq("t6_rst_flags", {brk[0], ferr[0], ovr[0], perr[0]}, 4'h0);
    check_eq("t6_rst_data", data_a, 8'h00);
    line = 1'b1;
    repeat (5) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (128) @(posedge clk);
    #1;
    send_frame(9'h03C, 8, 1, 1'b0, 1, 1'b1, 64);
    @(negedge clk);
    check_eq("t6_data_a", {valid[0], data_a}, {1'b1, 8'h3C});
    check_eq("t6_errs_a", {perr[0], ferr[0], brk[0], ovr[0]}, 4'h0);

    // width regressions: 5N1 at 8x, 7E1, 9O2
    #1 sel = 3'd2;
    send_frame(9'h01C, 5, 0, 1'b0, 1, 1'b1, 32);
    @(negedge clk);
    check_eq("t6_data_c", {valid[2], data_c}, {1'b1, 5'h1C});
    check_eq("t6_errs_c", {perr[2], ferr[2], brk[2]}, 3'h0);
    #1 sel = 3'd3;
    send_frame(9'h03C, 7, 1, 1'b0, 1, 1'b1, 64);
    @(negedge clk);
    check_eq("t6_data_d", {valid[3], data_d}, {1'b1, 7'h3C});
    check_eq("t6_errs_d", {perr[3], ferr[3], brk[3]}, 3'h0);
    #1 sel = 3'd4;
    send_frame(9'h03C, 9, 1, 1'b1, 2, 1'b1, 64);
    @(negedge clk);
    check_eq("t6_data_e", {valid[4], data_e}, {1'b1, 9'h03C});
    check_eq("t6_errs_e", {perr[4], ferr[4], brk[4]}, 3'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
